// File: rtl/sort_sequencer.sv
`default_nettype none
// ============================================================================
// sort_sequencer : odd-even transposition sort of a Depth-word batch; every
//                  compare-swap is a four-phase handshake with an external unit.
// Revision       : 1.0
// ============================================================================
module sort_sequencer #(
  parameter int Width = 32,
  parameter int Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data,
  output logic             busy,
  output logic             cs_req,
  input  logic             cs_fin,
  output logic [Width-1:0] cs_a,
  output logic [Width-1:0] cs_b,
  input  logic [Width-1:0] cs_smaller,
  input  logic [Width-1:0] cs_bigger
);

  localparam int IdxW = $clog2(Depth);
  localparam logic [IdxW-1:0] c_one       = IdxW'(1);
  localparam logic [IdxW-1:0] c_two       = IdxW'(2);
  localparam logic [IdxW-1:0] c_last_idx  = IdxW'(Depth - 1);
  localparam logic [IdxW-1:0] c_last_even = IdxW'(Depth - 2);
  localparam logic [IdxW-1:0] c_last_odd  = IdxW'(Depth - 3);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    RELEASE = 3'd4,
    NEXT    = 3'd5,
    DRAIN   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic             fin_meta_q, fin_s_q;
  logic [IdxW-1:0]  pass_q, pass_d;
  logic [IdxW-1:0]  i_q, i_d;
  logic [IdxW-1:0]  rd_q, rd_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [Width-1:0] cs_a_q, cs_a_d;
  logic [Width-1:0] cs_b_q, cs_b_d;
  logic             cs_req_q, cs_req_d;
  logic             load_pair;
  logic             pass_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      fin_meta_q <= 1'b0;
      fin_s_q    <= 1'b0;
    end else begin
      fin_meta_q <= cs_fin;
      fin_s_q    <= fin_meta_q;
    end
  end

  assign pass_end = pass_q[0] ? (i_q == c_last_odd) : (i_q == c_last_even);

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    i_d       = i_q;
    rd_d      = rd_q;
    mem_d     = mem_q;
    cs_a_d    = cs_a_q;
    cs_b_d    = cs_b_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_pair = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A stale fin from an interrupted handshake must clear before a new batch.
        in_ready = !fin_s_q && !rst;
        if (in_valid && in_ready) begin
          mem_d[0] = in_data;
          i_d      = c_one;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_d[i_q] = in_data;
          if (i_q == c_last_idx) begin
            pass_d    = '0;
            i_d       = '0;
            load_pair = 1'b1;
            state_d   = ISSUE;
          end else begin
            i_d = i_q + c_one;
          end
        end
      end
      ISSUE: begin
        if (fin_s_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        mem_d[i_q]         = cs_smaller;
        mem_d[i_q + c_one] = cs_bigger;
        state_d            = RELEASE;
      end
      RELEASE: begin
        if (!fin_s_q) state_d = NEXT;
      end
      NEXT: begin
        if (!pass_end) begin
          i_d       = i_q + c_two;
          load_pair = 1'b1;
          state_d   = ISSUE;
        end else if ((pass_q == c_last_idx) || (Depth == 2)) begin
          // With Depth=2 the odd pass has no pairs, so pass 0 is the last one.
          rd_d    = '0;
          state_d = DRAIN;
        end else begin
          pass_d    = pass_q + c_one;
          i_d       = pass_q[0] ? '0 : c_one;
          load_pair = 1'b1;
          state_d   = ISSUE;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_q == c_last_idx) state_d = IDLE;
          else                    rd_d    = rd_q + c_one;
        end
      end
      default: state_d = IDLE;
    endcase
    // Operands are read from the post-write array so the last loaded word is seen.
    if (load_pair) begin
      cs_a_d = mem_d[i_d];
      cs_b_d = mem_d[i_d + c_one];
    end
    cs_req_d = (state_d == ISSUE) || (state_d == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pass_q   <= '0;
      i_q      <= '0;
      rd_q     <= '0;
      cs_a_q   <= '0;
      cs_b_q   <= '0;
      cs_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      i_q      <= i_d;
      rd_q     <= rd_d;
      cs_a_q   <= cs_a_d;
      cs_b_q   <= cs_b_d;
      cs_req_q <= cs_req_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_data = mem_q[rd_q];
  assign busy     = (state_q != IDLE);
  assign cs_req   = cs_req_q;
  assign cs_a     = cs_a_q;
  assign cs_b     = cs_b_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sort_sequencer : randomized self-checking bench for sort_sequencer with
//                     behavioural compare-swap responders and a sorting model.
// Revision          : 1.0
// ============================================================================
module tb_sort_sequencer;
  localparam int W = 32;
  typedef logic [W-1:0] wq_t [$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8, cs_req8, cs_fin8;
  logic [W-1:0] in_data8, out_data8, cs_a8, cs_b8, cs_sm8, cs_bg8;
  logic         in_valid2, in_ready2, out_valid2, out_ready2, busy2, cs_req2, cs_fin2;
  logic [W-1:0] in_data2, out_data2, cs_a2, cs_b2, cs_sm2, cs_bg2;

  sort_sequencer #(.Width(W), .Depth(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .busy(busy8), .cs_req(cs_req8), .cs_fin(cs_fin8),
    .cs_a(cs_a8), .cs_b(cs_b8), .cs_smaller(cs_sm8), .cs_bigger(cs_bg8)
  );

  sort_sequencer #(.Width(W), .Depth(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .busy(busy2), .cs_req(cs_req2), .cs_fin(cs_fin2),
    .cs_a(cs_a2), .cs_b(cs_b2), .cs_smaller(cs_sm2), .cs_bigger(cs_bg2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the k-th output is the k-th smallest input word (unsigned).
  function automatic wq_t model_sort(input wq_t in);
    wq_t res;
    res = {};
    foreach (in[k]) begin
      int pos;
      pos = 0;
      while (pos < res.size() && res[pos] <= in[k]) pos++;
      res.insert(pos, in[k]);
    end
    return res;
  endfunction

  // Testbench copy of the fin synchronizer, used to judge handshake timing.
  logic fm8, fs8;
  always @(posedge clk) begin
    if (rst) begin
      fm8 <= 1'b0;
      fs8 <= 1'b0;
    end else begin
      fm8 <= cs_fin8;
      fs8 <= fm8;
    end
  end

  int lat_lo8 = 1;
  int lat_hi8 = 1;
  int hold8   = 0;

  initial begin : resp8
    int d;
    cs_fin8 = 1'b0; cs_sm8 = '0; cs_bg8 = '0;
    forever begin
      @(posedge clk); #1;
      if (cs_req8 && !cs_fin8) begin
        d = $urandom_range(lat_hi8, lat_lo8);
        repeat (d) @(posedge clk);
        #1;
        cs_sm8  = (cs_a8 < cs_b8) ? cs_a8 : cs_b8;
        cs_bg8  = (cs_a8 < cs_b8) ? cs_b8 : cs_a8;
        cs_fin8 = 1'b1;
        repeat (hold8) @(posedge clk);
        #1;
        for (int k = 0; k < 5000 && cs_req8; k++) begin
          @(posedge clk); #1;
        end
        d = $urandom_range(lat_hi8, lat_lo8);
        repeat (d) @(posedge clk);
        #1 cs_fin8 = 1'b0;
      end
    end
  end

  initial begin : resp2
    cs_fin2 = 1'b0; cs_sm2 = '0; cs_bg2 = '0;
    forever begin
      @(posedge clk); #1;
      if (cs_req2 && !cs_fin2) begin
        @(posedge clk); #1;
        cs_sm2  = (cs_a2 < cs_b2) ? cs_a2 : cs_b2;
        cs_bg2  = (cs_a2 < cs_b2) ? cs_b2 : cs_a2;
        cs_fin2 = 1'b1;
        for (int k = 0; k < 5000 && cs_req2; k++) begin
          @(posedge clk); #1;
        end
        @(posedge clk); #1 cs_fin2 = 1'b0;
      end
    end
  end

  wq_t got8;
  int  rises8 = 0, rises2 = 0;
  int  rise_viol = 0, stab_viol = 0, stall_viol = 0, excl_viol = 0;
  bit  mon_en = 1'b0;

  initial begin : mon
    logic pr, pf, pr2, pstall;
    logic [W-1:0] pa, pb, pd;
    pr = 1'b0; pf = 1'b0; pr2 = 1'b0; pstall = 1'b0; pa = '0; pb = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (cs_req8 && !pr) begin
        rises8++;
        if (fs8) rise_viol++;
      end
      if (mon_en && (pr || pf) && (cs_req8 || fs8) && (cs_a8 !== pa || cs_b8 !== pb)) stab_viol++;
      if (pstall && out_valid8 && out_data8 !== pd) stall_viol++;
      if (out_valid8 && (in_ready8 || !busy8)) excl_viol++;
      if (out_valid8 && out_ready8) got8.push_back(out_data8);
      if (cs_req2 && !pr2) rises2++;
      pr = cs_req8; pf = fs8; pa = cs_a8; pb = cs_b8; pd = out_data8; pr2 = cs_req2;
      pstall = out_valid8 && !out_ready8;
    end
  end

  task automatic load8(input wq_t w);
    int t;
    foreach (w[k]) begin
      @(posedge clk); #1;
      in_valid8 = 1'b1;
      in_data8  = w[k];
      @(negedge clk);
      t = 0;
      while (!in_ready8 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready8) begin
        check("load_timeout", W'(0), W'(1));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic run_batch8(input wq_t w, input bit bp, input string tag);
    wq_t exp;
    int  base, t;
    got8.delete();
    base = rises8;
    load8(w);
    t = 0;
    while (got8.size() < 8 && t < 20000) begin
      @(posedge clk); #1;
      out_ready8 = bp ? 1'($urandom_range(1)) : 1'b1;
      t++;
    end
    out_ready8 = 1'b0;
    exp = model_sort(w);
    check({tag, "_count"}, W'(got8.size()), W'(8));
    for (int k = 0; k < 8 && k < got8.size(); k++)
      check($sformatf("%s_out%0d", tag, k), got8[k], exp[k]);
    check({tag, "_handshakes"}, W'(rises8 - base), W'(28));
    @(negedge clk);
    check({tag, "_idle"}, W'(busy8), W'(0));
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    wq_t w;
    int  t;
    rst = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_in_ready",  W'(in_ready8),  W'(0));
    check("rst_out_valid", W'(out_valid8), W'(0));
    check("rst_busy",      W'(busy8),      W'(0));
    check("rst_cs_req",    W'(cs_req8),    W'(0));
    check("rst_cs_a",      cs_a8,          W'(0));
    check("rst_cs_b",      cs_b8,          W'(0));
    check("rst_busy2",     W'(busy2),      W'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", W'(in_ready8), W'(1));
    mon_en = 1'b1;

    w = '{7, 3, 9, 1, 8, 2, 6, 4};
    run_batch8(w, 1'b0, "basic");
    w = '{5, 5, 5, 5, 5, 5, 5, 5};
    run_batch8(w, 1'b0, "equal");
    w = '{8, 7, 6, 5, 4, 3, 2, 1};
    run_batch8(w, 1'b0, "desc");

    lat_lo8 = 0; lat_hi8 = 20;
    for (int b = 0; b < 5; b++) begin
      w = {};
      for (int k = 0; k < 8; k++)
        w.push_back((b % 2 == 1) ? W'($urandom_range(7)) : W'($urandom));
      run_batch8(w, 1'b1, $sformatf("rnd%0d", b));
    end

    // Reset while the DUT sits in CAPTURE and the responder holds fin high.
    lat_lo8 = 1; lat_hi8 = 1; hold8 = 10; mon_en = 1'b0;
    w = '{11, 10, 9, 8, 7, 6, 5, 4};
    load8(w);
    t = 0;
    while (!cs_fin8 && t < 2000) begin
      @(posedge clk); #2;
      t++;
    end
    check("rst_fin_seen", W'(cs_fin8), W'(1));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("midrst_in_ready%0d", k), W'(in_ready8), W'(!fs8));
      check($sformatf("midrst_cs_req%0d", k),   W'(cs_req8),   W'(0));
    end
    check("midrst_busy", W'(busy8), W'(0));
    t = 0;
    while ((cs_fin8 || fs8) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("midrst_fin_low", W'(fs8), W'(0));
    hold8 = 0; lat_lo8 = 0; lat_hi8 = 20; mon_en = 1'b1;
    w = {};
    for (int k = 0; k < 8; k++) w.push_back(W'($urandom));
    run_batch8(w, 1'b1, "post_rst");

    // Depth=2 batch: a single handshake and extreme values.
    t = rises2;
    @(posedge clk); #1;
    in_valid2 = 1'b1; in_data2 = 32'hFFFF_FFFF;
    @(negedge clk);
    check("d2_ready0", W'(in_ready2), W'(1));
    @(posedge clk); #1;
    in_data2 = '0;
    @(negedge clk);
    check("d2_ready1", W'(in_ready2), W'(1));
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    for (int k = 0; k < 200 && !out_valid2; k++) @(negedge clk);
    check("d2_valid0", W'(out_valid2), W'(1));
    check("d2_out0",   out_data2,      W'(0));
    out_ready2 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("d2_valid1", W'(out_valid2), W'(1));
    check("d2_out1",   out_data2,      32'hFFFF_FFFF);
    check("d2_busy1",  W'(busy2),      W'(1));
    @(posedge clk); @(negedge clk);
    out_ready2 = 1'b0;
    check("d2_busy_fall", W'(busy2),      W'(0));
    check("d2_valid_end", W'(out_valid2), W'(0));
    check("d2_handshakes", W'(rises2 - t), W'(1));

    check("cs_operand_stable", W'(stab_viol),  W'(0));
    check("req_rise_fin_low",  W'(rise_viol),  W'(0));
    check("stall_hold",        W'(stall_viol), W'(0));
    check("in_out_exclusive",  W'(excl_viol),  W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 SHALL have parameter Width, default 32, meaning the bit width of every data word.
REQ-002 SHALL have parameter Depth, default 8, meaning the words per batch; legal values are even and >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: load word offered.
REQ-006 SHALL have port in_ready, output, 1 bit: load word accepted when in_valid is also 1.
REQ-007 SHALL have port in_data, input, Width bits: load word.
REQ-008 SHALL have port out_valid, output, 1 bit: sorted word offered.
REQ-009 SHALL have port out_ready, input, 1 bit: sorted word taken when out_valid is also 1.
REQ-010 SHALL have port out_data, output, Width bits: sorted word, ascending order.
REQ-011 SHALL have port busy, output, 1 bit: high in all states except IDLE.
REQ-012 SHALL have port cs_req, output, 1 bit: four-phase request to an external compare-swap responder.
REQ-013 SHALL have port cs_fin, input, 1 bit: responder completion, asynchronous to clk.
REQ-014 SHALL have port cs_a, output, Width bits: first operand, held stable while cs_req or synced fin is high.
REQ-015 SHALL have port cs_b, output, Width bits: second operand, with the same stability rule as cs_a.
REQ-016 SHALL have port cs_smaller, input, Width bits: min(cs_a, cs_b), valid while cs_fin is high.
REQ-017 SHALL have port cs_bigger, input, Width bits: max(cs_a, cs_b), valid while cs_fin is high.

Function
REQ-018 SHALL pass cs_fin through a two-flop synchronizer; the second stage output is fin_s, and only fin_s SHALL be used.
REQ-019 SHALL implement states IDLE, LOAD, ISSUE, CAPTURE, RELEASE, NEXT and DRAIN in a register array mem[0..Depth-1].
REQ-020 In IDLE, in_ready SHALL be 1 only when fin_s is 0; the first accepted word SHALL be written to mem[0] and the state SHALL move to LOAD.
REQ-021 In LOAD, in_ready SHALL be 1 and word k SHALL be written to mem[k]; after mem[Depth-1] is written the state SHALL move to ISSUE with pass=0 and the first pair selected.
REQ-022 Even passes SHALL use pairs (0,1),(2,3),...; odd passes SHALL use pairs (1,2),(3,4),...,(Depth-3,Depth-2); an odd pass with no pairs (Depth=2) SHALL be skipped.
REQ-023 In ISSUE, cs_a SHALL equal mem[i], cs_b SHALL equal mem[i+1] and cs_req SHALL be 1; when fin_s is 1 the state SHALL move to CAPTURE.
REQ-024 In CAPTURE, mem[i] SHALL be loaded with cs_smaller and mem[i+1] with cs_bigger, cs_req SHALL stay 1, and the next state SHALL be RELEASE.
REQ-025 In RELEASE, cs_req SHALL be 0, cs_a and cs_b SHALL be held, and when fin_s is 0 the state SHALL move to NEXT.
REQ-026 NEXT SHALL last one cycle: it advances i by 2, or at the end of a pass increments pass and reloads i to 0 or 1; after pass Depth-1 it SHALL go to DRAIN with rd=0, otherwise to ISSUE.
REQ-027 Exactly Depth passes SHALL run, for Depth*(Depth-1)/2 handshakes in total; the result SHALL be non-decreasing unsigned order.
REQ-028 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal mem[rd]; each out_valid && out_ready cycle SHALL increment rd, and after rd=Depth-1 is taken the state SHALL return to IDLE.
REQ-029 Stalls: out_valid=1 with out_ready=0 SHALL hold out_data and rd unchanged; a responder that never returns cs_fin SHALL hold ISSUE indefinitely with no timeout.
REQ-030 in_ready SHALL be 0 outside IDLE and LOAD, and out_valid SHALL be 0 outside DRAIN.
REQ-031 Minimum handshake cost SHALL be 6 cycles: 2 cycles of synchronizer rise, CAPTURE, 2 cycles of synchronizer fall, NEXT.

Reset
REQ-032 On rst=1 the block SHALL force the state to IDLE and clear pass, i and rd, holding in_ready, out_valid, busy and cs_req at 0 from the next edge; cs_a and cs_b SHALL reset to 0, while mem contents need not reset.
REQ-033 After a reset that lands mid-handshake, no new cs_req SHALL be issued until fin_s has returned to 0; this holds through the in_ready gating of REQ-020.
REQ-034 The synchronizer flops SHALL reset to 0.

Verification
REQ-035 With Depth=8, load 7,3,9,1,8,2,6,4 and use a 1-cycle-latency responder -> out = 1,2,3,4,6,7,8,9, with exactly 28 cs_req rising edges.
REQ-036 Load all-equal 5s, then load descending 8..1 -> outputs are all 5, then 1..8; check cs_a and cs_b stay stable whenever cs_req=1.
REQ-037 Use a responder with random 0-20 cycle fin delay and random out_ready backpressure -> order is correct, no output word is dropped or duplicated, and cs_req never rises while fin_s=1.
REQ-038 Assert rst while in CAPTURE with the responder still holding fin high for 10 cycles -> in_ready stays 0 until fin_s is 0, and the next batch sorts correctly.
REQ-039 With Depth=2, load 0xFFFFFFFF then 0 -> exactly 1 handshake, out = 0 then 0xFFFFFFFF, and busy falls the cycle after the last output is taken.
